// File: rtl/spi_master.sv
// spi_master: SPI mode-0 master that sends one parallel word MSB-first and returns the word captured from MISO.
// Ports:
//   i_clk, i_rst              system clock, asynchronous active-high reset
//   i_TX_data, i_TX_valid     word to send and its valid strobe
//   o_TX_ready                high while idle and able to accept a word
//   o_RX_data, o_RX_valid     last received word and its one-cycle update pulse
//   o_busy                    high while a transfer is in progress
//   o_sck, o_mosi, o_ssel_n   SPI clock (idles low), data out, active-low select
//   i_miso                    SPI data in, sampled in the i_clk domain
module spi_master #(
    parameter int DATA_BITS = 16,
    parameter int CLK_DIV   = 4,
    parameter int CS_SETUP  = 2,
    parameter int CS_HOLD   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DATA_BITS-1:0] i_TX_data,
    input  logic                 i_TX_valid,
    output logic                 o_TX_ready,
    output logic [DATA_BITS-1:0] o_RX_data,
    output logic                 o_RX_valid,
    output logic                 o_busy,
    output logic                 o_sck,
    output logic                 o_mosi,
    output logic                 o_ssel_n,
    input  logic                 i_miso
);
    // One counter is shared by setup, divider and hold phases, so size it for the largest.
    localparam int CNT_MAX = (CLK_DIV > CS_SETUP) ? ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD)
                                                  : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BITS_ALL   = BW'(DATA_BITS);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bits;
    logic [DATA_BITS-1:0] tx_sr;
    logic [DATA_BITS-1:0] rx_sr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bits       <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            o_TX_ready <= 1'b1;
            o_RX_data  <= '0;
            o_RX_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_sck      <= 1'b0;
            o_mosi     <= 1'b0;
            o_ssel_n   <= 1'b1;
        end else begin
            o_RX_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_TX_valid && o_TX_ready) begin
                        tx_sr      <= i_TX_data;
                        o_mosi     <= i_TX_data[DATA_BITS-1];
                        o_ssel_n   <= 1'b0;
                        o_TX_ready <= 1'b0;
                        o_busy     <= 1'b1;
                        cnt        <= '0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        bits  <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt != DIV_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt   <= '0;
                        o_sck <= ~o_sck;
                        if (!o_sck) begin
                            // rising edge: capture MISO
                            rx_sr <= {rx_sr[DATA_BITS-2:0], i_miso};
                            bits  <= bits + 1'b1;
                        end else if (bits == BITS_ALL) begin
                            // last falling edge: no further bit to drive
                            state <= HOLD;
                        end else begin
                            tx_sr  <= tx_sr << 1;
                            o_mosi <= tx_sr[DATA_BITS-2];
                        end
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        o_ssel_n   <= 1'b1;
                        o_mosi     <= 1'b0;
                        o_RX_data  <= rx_sr;
                        o_RX_valid <= 1'b1;
                        o_TX_ready <= 1'b1;
                        o_busy     <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
